expu_log2: RTL and testbench
============================

Name: expu_log2

Overview:
- Iterative, handshaked base-2 logarithm unit for one FP16ALT (bfloat16) operand.
- Computes log2(x) as the unbiased exponent plus the mantissa fraction f, plus the quadratic correction c(f) = K·f·(1−f).
- It is the inverse-direction companion of the exponential correction path in expu.
- Used for log-domain normalisation in the softmax datapath.
- Processes one operand at a time through a fixed multi-cycle FSM.

Parameters:
- FPFORMAT, FP16ALT, floating-point format of input and result. WIDTH, MANTISSA_BITS (M) and EXPONENT_BITS (E) are derived from it via fpnew_pkg.
- COEFFICIENT_FRACTION, 8, fractional bits of K.
- CORR_SURPLUS_BITS, 3, extra fractional bits kept in the sum. FRAC = M + CORR_SURPLUS_BITS.
- K_REAL, 0.34375, correction coefficient. K = int'(K_REAL·2^COEFFICIENT_FRACTION) = 88 at defaults.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous flush to IDLE
- op_i  in  WIDTH  operand
- valid_i  in  1  operand valid
- ready_o  out  1  unit can accept an operand
- res_o  out  WIDTH  log2 result
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts the result

Behaviour:
- Reset is asynchronous, active-low, with one clock, as already decided.
- Reset values: state IDLE, ready_o=1, valid_o=0, res_o=0. All internal registers are 0.
- FSM states: IDLE, MUL, ADD, NORM, DONE.
  - IDLE: ready_o=1. On valid_i&ready_o, capture op_i.
    - Special operand: go to DONE with the special result.
    - Otherwise: go to MUL.
  - MUL: compute and register c. Go to ADD.
  - ADD: form the signed sum; register its sign and magnitude. Go to NORM.
  - NORM: normalise; register res_o. Go to DONE.
  - DONE: valid_o=1, and res_o is held stable. When ready_i=1, go to IDLE.
- ready_o is asserted only in IDLE. No new operand is accepted in the same cycle a result is handed off.
- Latency:
  - Normal operand: valid_o rises 4 cycles after the accept edge.
  - Special operand: valid_o rises 1 cycle after the accept edge.
- Special cases, decoded in IDLE:
  - Zero or denormal (exponent field 0, either sign): −inf, 0xFF80.
  - Sign bit set on a nonzero value: canonical NaN, 0x7FC0.
  - NaN input: canonical NaN, 0x7FC0.
  - +inf: +inf, 0x7F80.
- MUL arithmetic:
  - f = mantissa field, as Q0.M.
  - p = f·(2^M − f), as Q0.2M.
  - c = (p·K) >> (2M + COEFFICIENT_FRACTION − FRAC), giving Q0.FRAC. The shift truncates.
- ADD arithmetic:
  - e = exponent field − bias, a signed value of E+1 bits.
  - s = {e, FRAC zeros} + (f << CORR_SURPLUS_BITS) + c, a signed fixed-point value with FRAC fractional bits.
  - Sign = MSB of s.
  - Magnitude = |s|, taken by two's-complement negation when s is negative.
- NORM:
  - Leading-one position q in the magnitude.
  - Result exponent = bias + q − FRAC.
  - Result mantissa = the M bits directly below the leading one. Truncate; no rounding.
  - If M exceeds the bits available below the leading one, zero-fill on the right.
  - Magnitude 0: result is +0, 0x0000.
  - Result sign = sum sign.
- clear_i has priority over every transition.
  - It forces IDLE, drops valid_o and zeroes res_o on the next edge.
  - If clear_i and valid_i are both high in IDLE, clear_i wins and the operand is not captured.
- Asynchronous reset mid-operation abandons the operation. Outputs return to their reset values immediately.
- op_i is ignored outside IDLE. Its value may change freely while the unit is busy.

Test Plan:
- 0x3F80 (1.0) -> 0x0000; valid_o exactly 4 cycles after accept.
- 0x3FC0 (1.5) -> 0x3F16 (0.5859375); check p=4096, c=88, s=600.
- 0x4080 (4.0) -> 0x4000. 0x3F00 (0.5) -> 0xBF80 (−1.0), exercising the negative path.
- Specials, each with 1-cycle latency:
  - 0x0000 -> 0xFF80
  - 0x0001 -> 0xFF80
  - 0xBF80 -> 0x7FC0
  - 0x7FC1 -> 0x7FC0
  - 0x7F80 -> 0x7F80
- Backpressure on 0x4000: hold ready_i=0 for 5 cycles.
  - valid_o stays 1 and res_o=0x3F80 stays stable.
  - ready_o stays 0, and valid_i pulses during the stall are ignored.
  - On the ready_i=1 cycle the unit returns to IDLE.
- Interruptions during 0x3FC0:
  - Assert clear_i in ADD: the unit returns to IDLE, valid_o never rises, and a following 0x3F80 gives 0x0000.
  - Repeat the run with rst_ni pulsed low in NORM: all outputs reach their reset values asynchronously.

Source files
------------

// File: rtl/expu_log2.sv
// -----------------------------------------------------------------------------
// expu_log2
//   Iterative base-2 logarithm unit for a single floating-point operand
//   (bfloat16 by default). The result is the unbiased exponent plus the
//   mantissa fraction f, refined by the quadratic correction K*f*(1-f).
//   One operand is in flight at a time; the FSM walks IDLE -> MUL -> ADD ->
//   NORM -> DONE, while special operands short-cut from IDLE straight to DONE.
//
// Ports
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   clear_i  : synchronous flush back to IDLE (drops valid_o, zeroes res_o)
//   op_i     : operand, sampled only when accepted in IDLE
//   valid_i  : operand valid
//   ready_o  : unit can accept an operand (IDLE only)
//   res_o    : log2 result, stable while valid_o is high
//   valid_o  : result valid
//   ready_i  : downstream accepts the result
// -----------------------------------------------------------------------------
module expu_log2 #(
  parameter logic [2:0]   FPFORMAT             = 3'd4,
  parameter int unsigned  COEFFICIENT_FRACTION = 8,
  parameter int unsigned  CORR_SURPLUS_BITS    = 3,
  parameter real          K_REAL               = 0.34375,
  // Format encoding follows fpnew: FP32, FP64, FP16, FP8, FP16ALT
  localparam int unsigned EXPONENT_BITS = (FPFORMAT == 3'd1) ? 11 :
                                          (FPFORMAT == 3'd2 || FPFORMAT == 3'd3) ? 5 : 8,
  localparam int unsigned MANTISSA_BITS = (FPFORMAT == 3'd0) ? 23 :
                                          (FPFORMAT == 3'd1) ? 52 :
                                          (FPFORMAT == 3'd2) ? 10 :
                                          (FPFORMAT == 3'd3) ? 2 : 7,
  localparam int unsigned WIDTH = 1 + EXPONENT_BITS + MANTISSA_BITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] op_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] res_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int unsigned E     = EXPONENT_BITS;
  localparam int unsigned M     = MANTISSA_BITS;
  localparam int unsigned FRAC  = M + CORR_SURPLUS_BITS;
  // Signed sum: E+1 integer bits (unbiased exponent) plus FRAC fraction bits
  localparam int unsigned SW    = E + 1 + FRAC;
  localparam int unsigned LW    = $clog2(SW);
  localparam int unsigned BIAS  = (1 << (E - 1)) - 1;
  localparam int unsigned PKW   = 2 * M + COEFFICIENT_FRACTION + 1;
  localparam int unsigned SHIFT = 2 * M + COEFFICIENT_FRACTION - FRAC;
  localparam int          K     = int'(K_REAL * (2.0 ** COEFFICIENT_FRACTION));

  typedef enum logic [2:0] {IDLE, MUL, ADD, NORM, DONE} state_e;

  state_e           state_q;
  logic             ready_q;
  logic             valid_q;
  logic [WIDTH-1:0] res_q;
  logic [E-1:0]     exp_q;
  logic [M-1:0]     mant_q;
  logic [FRAC-1:0]  corr_q;
  logic             sign_q;
  logic [SW-1:0]    mag_q;

  logic             expZero, expOnes, manNonZero, isSpecial;
  logic [WIDTH-1:0] specialRes;
  logic [M:0]       compl;
  logic [2*M-1:0]   prod_d;
  logic [PKW-1:0]   scaled;
  logic [FRAC-1:0]  corr_d;
  logic signed [E:0] expUnb;
  logic [SW-1:0]    sum_d;
  logic [SW-1:0]    mag_d;
  logic [LW-1:0]    lead;
  logic [SW-1:0]    normShifted;
  logic [E-1:0]     expOut;
  logic [M-1:0]     manOut;
  logic [WIDTH-1:0] res_d;

  // Special operand decode on the live input. Zero/denormal wins over the
  // sign check so that -0 gives -inf rather than NaN.
  always_comb begin
    expZero    = ~|op_i[M +: E];
    expOnes    = &op_i[M +: E];
    manNonZero = |op_i[M-1:0];
    isSpecial  = expZero | expOnes | op_i[WIDTH-1];
    specialRes = {1'b0, {E{1'b1}}, {M{1'b0}}};
    if (expZero) begin
      specialRes = {1'b1, {E{1'b1}}, {M{1'b0}}};
    end else if ((expOnes && manNonZero) || op_i[WIDTH-1]) begin
      specialRes = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    end
  end

  // Correction term: c = (f*(1-f)*K) scaled down to Q0.FRAC, truncating.
  always_comb begin
    compl  = {1'b1, {M{1'b0}}} - {1'b0, mant_q};
    prod_d = {{M{1'b0}}, mant_q} * {{(M-1){1'b0}}, compl};
    scaled = PKW'(prod_d) * PKW'(K);
    corr_d = FRAC'(scaled >> SHIFT);
  end

  // Signed fixed-point sum of exponent, fraction and correction.
  always_comb begin
    expUnb = $signed({1'b0, exp_q}) - $signed((E + 1)'(BIAS));
    sum_d  = {expUnb, {FRAC{1'b0}}}
           + SW'({mant_q, {CORR_SURPLUS_BITS{1'b0}}})
           + SW'(corr_q);
    mag_d  = sum_d[SW-1] ? (~sum_d + SW'(1)) : sum_d;
  end

  // Normalisation: place the leading one at the MSB, keep the M bits below
  // it (shifting left zero-fills when fewer bits are available).
  always_comb begin
    lead = '0;
    for (int i = 0; i < SW; i++) begin
      if (mag_q[i]) lead = LW'(i);
    end
    normShifted = mag_q << (LW'(SW - 1) - lead);
    manOut      = M'(normShifted >> (SW - 1 - M));
    expOut      = E'(int'(BIAS) + int'(lead) - int'(FRAC));
    res_d       = (mag_q == '0) ? '0 : {sign_q, expOut, manOut};
  end

  // Control FSM with registered handshake outputs. valid_o rises one cycle
  // after entering DONE, and the hand-off returns to IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      res_q   <= '0;
      exp_q   <= '0;
      mant_q  <= '0;
      corr_q  <= '0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
    end else if (clear_i) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && ready_q) begin
            exp_q   <= op_i[M +: E];
            mant_q  <= op_i[M-1:0];
            ready_q <= 1'b0;
            if (isSpecial) begin
              res_q   <= specialRes;
              state_q <= DONE;
            end else begin
              state_q <= MUL;
            end
          end
        end
        MUL: begin
          corr_q  <= corr_d;
          state_q <= ADD;
        end
        ADD: begin
          sign_q  <= sum_d[SW-1];
          mag_q   <= mag_d;
          state_q <= NORM;
        end
        NORM: begin
          res_q   <= res_d;
          state_q <= DONE;
        end
        DONE: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign res_o   = res_q;

endmodule

// File: tb/tb_expu_log2.sv
// -----------------------------------------------------------------------------
// tb_expu_log2
//   Directed bench for expu_log2. Expected results are queued as operands are
//   accepted and popped when the unit presents a result.
// -----------------------------------------------------------------------------
module tb_expu_log2;

  logic        clk = 1'b0;
  logic        rstN;
  logic        clear;
  logic [15:0] op;
  logic        validIn;
  logic        readyOut;
  logic [15:0] res;
  logic        validOut;
  logic        readyIn;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] expQ[$];

  logic [15:0] specOp  [5] = '{16'h0000, 16'h0001, 16'hBF80, 16'h7FC1, 16'h7F80};
  logic [15:0] specRes [5] = '{16'hFF80, 16'hFF80, 16'h7FC0, 16'h7FC0, 16'h7F80};

  expu_log2 dut (
    .clk_i   (clk),
    .rst_ni  (rstN),
    .clear_i (clear),
    .op_i    (op),
    .valid_i (validIn),
    .ready_o (readyOut),
    .res_o   (res),
    .valid_o (validOut),
    .ready_i (readyIn)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Hard stop in case something upstream never returns
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One compare: counts it, reports tag/observed/expected on a miss
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and settle just after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present an operand for one accept edge; optionally queue its result
  task automatic applyStimulus(input logic [15:0] opVal, input logic [15:0] expRes, input bit push);
    int waitCyc = 0;
    while (readyOut !== 1'b1 && waitCyc < 20) begin
      tick(1);
      waitCyc++;
    end
    if (readyOut !== 1'b1) checkOutput("ready_timeout", {31'd0, readyOut}, 32'd1);
    op      = opVal;
    validIn = 1'b1;
    if (push) expQ.push_back(expRes);
    tick(1);
    validIn = 1'b0;
    op      = 16'($urandom);
  endtask

  // Wait for valid_o, check latency and value, optionally stall, then hand off
  task automatic drainResult(input string tag, input int expLat, input int startCyc, input int holdCyc);
    int          cyc = startCyc;
    logic [15:0] expRes = 16'h0000;
    while (validOut !== 1'b1 && cyc < 20) begin
      tick(1);
      cyc++;
    end
    checkOutput({tag, "_latency"}, cyc, expLat);
    checkOutput({tag, "_queued"}, {31'd0, expQ.size() > 0}, 32'd1);
    if (expQ.size() > 0) expRes = expQ.pop_front();
    checkOutput({tag, "_res"}, {16'd0, res}, {16'd0, expRes});
    for (int i = 0; i < holdCyc; i++) begin
      validIn = i[0];
      op      = 16'h3F80;
      tick(1);
      checkOutput({tag, "_stall_valid"}, {31'd0, validOut}, 32'd1);
      checkOutput({tag, "_stall_res"}, {16'd0, res}, {16'd0, expRes});
      checkOutput({tag, "_stall_ready"}, {31'd0, readyOut}, 32'd0);
    end
    validIn = 1'b0;
    readyIn = 1'b1;
    tick(1);
    readyIn = 1'b0;
    checkOutput({tag, "_handoff_ready"}, {31'd0, readyOut}, 32'd1);
    checkOutput({tag, "_handoff_valid"}, {31'd0, validOut}, 32'd0);
  endtask

  initial begin
    rstN    = 1'b0;
    clear   = 1'b0;
    op      = 16'h0000;
    validIn = 1'b0;
    readyIn = 1'b0;
    tick(2);
    checkOutput("reset_ready", {31'd0, readyOut}, 32'd1);
    checkOutput("reset_valid", {31'd0, validOut}, 32'd0);
    checkOutput("reset_res", {16'd0, res}, 32'd0);
    rstN = 1'b1;
    tick(1);

    // 1.0 -> 0.0 with the full four-cycle latency
    applyStimulus(16'h3F80, 16'h0000, 1'b1);
    drainResult("one", 4, 0, 0);

    // 1.5 -> 0.5859375, with the intermediate products inspected
    applyStimulus(16'h3FC0, 16'h3F16, 1'b1);
    checkOutput("one_five_prod", 32'(dut.prod_d), 32'd4096);
    tick(1);
    checkOutput("one_five_corr", 32'(dut.corr_q), 32'd88);
    tick(1);
    checkOutput("one_five_mag", 32'(dut.mag_q), 32'd600);
    checkOutput("one_five_sign", {31'd0, dut.sign_q}, 32'd0);
    drainResult("one_five", 4, 2, 0);

    // 4.0 -> 2.0 and 0.5 -> -1.0 (negative sum path)
    applyStimulus(16'h4080, 16'h4000, 1'b1);
    drainResult("four", 4, 0, 0);
    applyStimulus(16'h3F00, 16'hBF80, 1'b1);
    drainResult("half", 4, 0, 0);

    // Special operands take the one-cycle short cut
    for (int i = 0; i < 5; i++) begin
      applyStimulus(specOp[i], specRes[i], 1'b1);
      drainResult($sformatf("special_%h", specOp[i]), 1, 0, 0);
    end

    // Backpressure: result held for five stalled cycles, valid_i pulses ignored
    applyStimulus(16'h4000, 16'h3F80, 1'b1);
    drainResult("backpressure", 4, 0, 5);
    tick(3);
    checkOutput("stall_pulses_ignored_valid", {31'd0, validOut}, 32'd0);
    checkOutput("stall_pulses_ignored_ready", {31'd0, readyOut}, 32'd1);

    // Clear while in ADD abandons the operation
    applyStimulus(16'h3FC0, 16'h0000, 1'b0);
    tick(1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    checkOutput("clear_ready", {31'd0, readyOut}, 32'd1);
    checkOutput("clear_valid", {31'd0, validOut}, 32'd0);
    checkOutput("clear_res", {16'd0, res}, 32'd0);
    tick(4);
    checkOutput("clear_no_valid", {31'd0, validOut}, 32'd0);

    // Clear beats a simultaneous valid_i in IDLE
    clear   = 1'b1;
    validIn = 1'b1;
    op      = 16'h4000;
    tick(1);
    clear   = 1'b0;
    validIn = 1'b0;
    checkOutput("clear_beats_valid_ready", {31'd0, readyOut}, 32'd1);
    tick(5);
    checkOutput("clear_beats_valid_no_result", {31'd0, validOut}, 32'd0);
    applyStimulus(16'h3F80, 16'h0000, 1'b1);
    drainResult("after_clear", 4, 0, 0);

    // Asynchronous reset while in NORM; res_o holds 0x4000 beforehand
    applyStimulus(16'h4080, 16'h4000, 1'b1);
    drainResult("pre_reset", 4, 0, 0);
    applyStimulus(16'h3FC0, 16'h0000, 1'b0);
    tick(2);
    checkOutput("norm_ready_busy", {31'd0, readyOut}, 32'd0);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async_reset_ready", {31'd0, readyOut}, 32'd1);
    checkOutput("async_reset_valid", {31'd0, validOut}, 32'd0);
    checkOutput("async_reset_res", {16'd0, res}, 32'd0);
    #2;
    rstN = 1'b1;
    tick(1);
    applyStimulus(16'h3FC0, 16'h3F16, 1'b1);
    drainResult("after_reset", 4, 0, 0);

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
